spi_chip_arbiter: RTL

- Shares one generic_spi_controller between two chip-side requesters (chip1, chip2) that sit behind the two-chip SPI bridge.
- Arbitrates round-robin and drives the bridge's chip1_sel so the select never changes while a transaction is in flight.
- Inserts a settle gap whenever the selected chip changes, issues the controller start pulse, waits for done, and returns read data with a one-cycle ack to the winning requester.

---
 rtl/spi_chip_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/spi_chip_arbiter.sv
// spi_chip_arbiter: round-robin share of one SPI controller by two chips.
// Optional WAIT timeout abort is compiled in with SPI_ARB_TIMEOUT_EN.
module spi_chip_arbiter #(
  parameter int DATA_W         = 32,
  parameter int SEL_SETTLE     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req1,
  input  logic [DATA_W-1:0] tx_data1,
  output logic              ack1,
  output logic [DATA_W-1:0] rx_data1,
  input  logic              req2,
  input  logic [DATA_W-1:0] tx_data2,
  output logic              ack2,
  output logic [DATA_W-1:0] rx_data2,
  output logic              spi_start,
  output logic [DATA_W-1:0] spi_tx_data,
  input  logic              spi_busy,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_rx_data,
  output logic              chip1_sel,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int SC_W = $clog2(SEL_SETTLE + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SEL_SETTLE - 1);

  state_t            r_state;
  logic [SC_W-1:0]   r_cnt;
  logic              r_sel;
  logic [1:0]        r_grant;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx1;
  logic [DATA_W-1:0] r_rx2;
  logic              r_ack1;
  logic              r_ack2;
  logic              r_last_c1;

  logic              w_any;
  logic              w_pick1;
  logic              w_expire;
  logic              w_finish;
  logic [DATA_W-1:0] w_cap;

  // Ties go to whichever chip was not served last.
  assign w_any   = req1 | req2;
  assign w_pick1 = req1 & (~req2 | ~r_last_c1);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to;
  logic            r_terr;

  assign w_expire = (r_to == TO_LAST) & ~spi_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to   <= '0;
      r_terr <= 1'b0;
    end else begin
      r_terr <= (r_state == ST_WAIT) & w_expire;
      if (r_state != ST_WAIT) r_to <= '0;
      else                    r_to <= r_to + TO_W'(1);
    end
  end

  assign timeout_err = r_terr;
`else
  logic w_unused_to;

  assign w_unused_to = (TIMEOUT_CYCLES != 0);
  assign w_expire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign w_finish = spi_done | w_expire;
  assign w_cap    = spi_done ? spi_rx_data : {DATA_W{1'b1}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_sel     <= 1'b1;
      r_grant   <= 2'b00;
      r_tx      <= '0;
      r_rx1     <= '0;
      r_rx2     <= '0;
      r_ack1    <= 1'b0;
      r_ack2    <= 1'b0;
      r_last_c1 <= 1'b0;
    end else begin
      r_ack1 <= 1'b0;
      r_ack2 <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick1 ? 2'b01 : 2'b10;
            r_tx    <= w_pick1 ? tx_data1 : tx_data2;
            if (w_pick1 != r_sel) begin
              r_sel   <= w_pick1;
              r_cnt   <= '0;
              r_state <= ST_SETTLE;
            end else begin
              r_state <= ST_START;
            end
          end
        end
        ST_SETTLE: begin
          if (r_cnt == SC_LAST) r_state <= ST_START;
          else                  r_cnt   <= r_cnt + SC_W'(1);
        end
        ST_START: begin
          if (!spi_busy) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_finish) begin
            if (r_grant[0]) begin
              r_rx1  <= w_cap;
              r_ack1 <= 1'b1;
            end else begin
              r_rx2  <= w_cap;
              r_ack2 <= 1'b1;
            end
            r_state <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_last_c1 <= r_grant[0];
          r_grant   <= 2'b00;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Start follows busy directly so it fires in the first idle cycle.
  assign spi_start   = (r_state == ST_START) & ~spi_busy;
  assign spi_tx_data = r_tx;
  assign chip1_sel   = r_sel;
  assign grant       = r_grant;
  assign ack1        = r_ack1;
  assign ack2        = r_ack2;
  assign rx_data1    = r_rx1;
  assign rx_data2    = r_rx2;

endmodule
